// File: rtl/sipo_frame_ctrl.sv
// Frame controller for a WIDTH-bit serial-in/parallel-out datapath with a valid/ready word output.
// Optional trailing even-parity bit per frame is enabled by defining PARITY_CHECK_EN.
module sipo_frame_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_err,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             par_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] dout_n;
  logic [WIDTH-1:0] shifted;
  logic             valid_n;
  logic [CNT_W-1:0] cnt_n;
  logic             ferr_n;
  logic             ovr_set;
  logic             ovr_n;
  logic             busy_n;
  logic             handshake;

`ifdef PARITY_CHECK_EN
  logic par_q, par_n;

  function automatic logic even_parity(input logic [WIDTH-1:0] word, input logic pbit);
    return ^{word, pbit};
  endfunction
`endif

  assign shifted   = {dout[WIDTH-2:0], sin};
  assign handshake = dout_valid & dout_ready;

  // Next-state and next-output decode for the frame FSM
  always_comb begin
    state_n = state;
    dout_n  = dout;
    valid_n = dout_valid;
    cnt_n   = bit_cnt;
    ferr_n  = 1'b0;
    ovr_set = 1'b0;
`ifdef PARITY_CHECK_EN
    par_n   = par_q;
`endif
    case (state)
      IDLE: begin
        if (sin_valid && sof) begin
          dout_n  = shifted;
          cnt_n   = CNT_ONE;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (sin_valid && sof) begin
          // Resync takes priority even when this would have been the last bit
          dout_n = shifted;
          cnt_n  = CNT_ONE;
          ferr_n = 1'b1;
        end else if (sin_valid) begin
          dout_n = shifted;
          cnt_n  = bit_cnt + CNT_ONE;
          if (bit_cnt == CNT_LAST) begin
`ifdef PARITY_CHECK_EN
            state_n = PAR;
`else
            state_n = HOLD;
            valid_n = 1'b1;
`endif
          end else begin
            state_n = SHIFT;
          end
        end else begin
          state_n = SHIFT;
        end
      end
      PAR: begin
`ifdef PARITY_CHECK_EN
        if (sin_valid && sof) begin
          dout_n  = shifted;
          cnt_n   = CNT_ONE;
          ferr_n  = 1'b1;
          state_n = SHIFT;
        end else if (sin_valid) begin
          par_n   = even_parity(dout, sin);
          valid_n = 1'b1;
          state_n = HOLD;
        end else begin
          state_n = PAR;
        end
`else
        state_n = IDLE;
`endif
      end
      HOLD: begin
        if (handshake) begin
          valid_n = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
`ifdef PARITY_CHECK_EN
          par_n   = 1'b0;
`endif
          if (sin_valid && sof) begin
            dout_n  = shifted;
            cnt_n   = CNT_ONE;
            state_n = SHIFT;
          end else begin
            dout_n  = dout;
          end
        end else if (sin_valid) begin
          ovr_set = 1'b1;
        end else begin
          state_n = HOLD;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (ovr_set) begin
      ovr_n = 1'b1;
    end else if (ovr_clr) begin
      ovr_n = 1'b0;
    end else begin
      ovr_n = overrun;
    end
    busy_n = (state_n == SHIFT) || (state_n == PAR);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      dout       <= '0;
      dout_valid <= 1'b0;
      bit_cnt    <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      dout       <= dout_n;
      dout_valid <= valid_n;
      bit_cnt    <= cnt_n;
      frame_err  <= ferr_n;
      overrun    <= ovr_n;
      busy       <= busy_n;
`ifdef PARITY_CHECK_EN
      par_q      <= par_n;
`endif
    end
  end

`ifdef PARITY_CHECK_EN
  assign par_err = par_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: table of frames plus hand-written corner sequences,
// with a scoreboard queue of expected words. Works with and without PARITY_CHECK_EN.
module tb_sipo_frame_ctrl;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset, sin, sin_valid, sof, dout_ready, ovr_clr;
  logic [W-1:0]  dout;
  logic          dout_valid, busy, frame_err, overrun, par_err;
  logic [CW-1:0] bit_cnt;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
    .bit_cnt(bit_cnt), .frame_err(frame_err), .overrun(overrun), .ovr_clr(ovr_clr),
    .par_err(par_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] word; logic par; } exp_t;
  typedef struct { logic [W-1:0] word; logic pbit; bit gapped; int hold; } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic s);
    sin = b; sof = s; sin_valid = 1'b1;
    step();
    sin = 1'b0; sof = 1'b0; sin_valid = 1'b0;
  endtask

  function automatic logic exp_par(input logic [W-1:0] word, input logic pbit);
`ifdef PARITY_CHECK_EN
    return ^{word, pbit};
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_exp(input logic [W-1:0] word, input logic pbit);
    exp_t e;
    e.word = word;
    e.par  = exp_par(word, pbit);
    exp_q.push_back(e);
  endtask

  task automatic send_parity(input logic pbit);
`ifdef PARITY_CHECK_EN
    check("par_state_cnt", bit_cnt, W);
    check("par_state_busy", busy, 1);
    check("par_state_valid", dout_valid, 0);
    send_bit(pbit, 1'b0);
`endif
  endtask

  task automatic send_frame(input vec_t v);
    push_exp(v.word, v.pbit);
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(v.word[i], i == W - 1);
      if (v.gapped && i > 0) step();
    end
    send_parity(v.pbit);
  endtask

  task automatic wait_word(input string name);
    int   n = 0;
    exp_t e;
    while (dout_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check({name, "_latency"}, n, 0);
    check({name, "_valid"}, dout_valid, 1);
    check({name, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({name, "_dout"}, dout, e.word);
      check({name, "_par_err"}, par_err, e.par);
    end
    check({name, "_bit_cnt"}, bit_cnt, W);
    check({name, "_busy"}, busy, 0);
  endtask

  task automatic hold_stable(input int cycles, input logic [W-1:0] word);
    for (int c = 0; c < cycles; c++) begin
      step();
      check("hold_dout", dout, word);
      check("hold_valid", dout_valid, 1);
    end
  endtask

  task automatic handshake();
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    check("hs_valid", dout_valid, 0);
    check("hs_bit_cnt", bit_cnt, 0);
    check("hs_busy", busy, 0);
    check("hs_par_err", par_err, 0);
  endtask

  task automatic set_vec(input int i, input logic [W-1:0] w, input logic p, input bit g, input int h);
    vecs[i].word = w; vecs[i].pbit = p; vecs[i].gapped = g; vecs[i].hold = h;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w3c;
    vec_t         v;
    reset = 1'b0; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0; dout_ready = 1'b0; ovr_clr = 1'b0;
    set_vec(0, 8'hA5, 1'b0, 1'b0, 0);
    set_vec(1, 8'hA5, 1'b1, 1'b1, 5);
    set_vec(2, 8'h3C, 1'b0, 1'b0, 2);
    set_vec(3, 8'hFF, 1'b1, 1'b1, 0);
    set_vec(4, 8'h00, 1'b0, 1'b0, 1);
    set_vec(5, 8'h81, 1'b1, 1'b0, 0);

    step(); step();
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", bit_cnt, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_par", par_err, 0);
    reset = 1'b1;

    // Bits without sof in IDLE are ignored
    send_bit(1'b1, 1'b0);
    check("idle_ignore_busy", busy, 0);
    check("idle_ignore_cnt", bit_cnt, 0);
    check("idle_ignore_ferr", frame_err, 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i]);
      wait_word("table");
      hold_stable(vecs[i].hold, vecs[i].word);
      handshake();
    end

    // Overrun: sticky, set wins over clear
    send_frame(vecs[0]);
    wait_word("ovr");
    send_bit(1'b0, 1'b0);
    check("ovr_set", overrun, 1);
    check("ovr_dout", dout, 8'hA5);
    check("ovr_valid", dout_valid, 1);
    step();
    check("ovr_sticky", overrun, 1);
    ovr_clr = 1'b1;
    send_bit(1'b1, 1'b0);
    check("ovr_set_wins", overrun, 1);
    step();
    ovr_clr = 1'b0;
    check("ovr_cleared", overrun, 0);
    check("ovr_dout_kept", dout, 8'hA5);
    handshake();

    // Resync after 5 bits, then resync after WIDTH-1 bits beats completion
    push_exp(8'hFF, 1'b0);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    check("resync_ferr", frame_err, 1);
    check("resync_cnt", bit_cnt, 1);
    send_bit(1'b1, 1'b0);
    check("resync_ferr_pulse", frame_err, 0);
    check("resync_cnt2", bit_cnt, 2);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    check("pre_last_cnt", bit_cnt, W - 1);
    send_bit(1'b1, 1'b1);
    check("late_resync_ferr", frame_err, 1);
    check("late_resync_cnt", bit_cnt, 1);
    check("late_resync_valid", dout_valid, 0);
    for (int i = 0; i < W - 1; i++) send_bit(1'b1, 1'b0);
    send_parity(1'b0);
    wait_word("resync");
    handshake();

    // Back-to-back: handshake in the same cycle as the next sof
    send_frame(vecs[1]);
    wait_word("b2b_first");
    w3c = 8'h3C;
    push_exp(w3c, 1'b1);
    dout_ready = 1'b1;
    send_bit(w3c[W-1], 1'b1);
    dout_ready = 1'b0;
    check("b2b_valid", dout_valid, 0);
    check("b2b_cnt", bit_cnt, 1);
    check("b2b_busy", busy, 1);
    for (int i = W - 2; i >= 0; i--) send_bit(w3c[i], 1'b0);
    send_parity(1'b1);
    wait_word("b2b_second");
    handshake();

    // Reset mid-frame discards partial data
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    reset = 1'b0;
    step();
    check("midrst_dout", dout, 0);
    check("midrst_cnt", bit_cnt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", dout_valid, 0);
    check("midrst_ferr", frame_err, 0);
    reset = 1'b1;
    v = vecs[2];
    send_frame(v);
    wait_word("post_rst");
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Controller that sequences a WIDTH-bit serial-in/parallel-out shift datapath. It accepts a framed serial bit stream with a per-bit qualifier and counts bits into a frame. It presents the completed word on a valid/ready parallel interface and holds it stable until consumed. It sits between a serial line front-end and the parallel word consumer.

Parameters:
WIDTH, 8, data bits per frame; legal range 2..32
CNT_W, $clog2(WIDTH+1), width of bit_cnt; derived, not overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low
sin  input  1  serial data bit
sin_valid  input  1  sin is valid this cycle
sof  input  1  start-of-frame marker; meaningful only with sin_valid
dout  output  WIDTH  assembled word; first received bit at dout[WIDTH-1]
dout_valid  output  1  dout holds a complete frame
dout_ready  input  1  consumer accepts dout
busy  output  1  frame in progress (SHIFT or PAR state)
bit_cnt  output  CNT_W  data bits accepted in current frame
frame_err  output  1  one-cycle pulse: frame restarted by sof before completion
overrun  output  1  sticky: bit offered while word held
ovr_clr  input  1  clears overrun
par_err  output  1  parity result; valid while dout_valid

Behaviour:
- Clock is clk. reset is synchronous and active-low: sampled on the clk edge, asserted when 0.
- Reset values: dout=0, dout_valid=0, busy=0, bit_cnt=0, frame_err=0, overrun=0, par_err=0, state=IDLE. Reset mid-frame discards partial data.
- Shift rule: on an accepted bit, dout <= {dout[WIDTH-2:0], sin}. An accepted bit is sin_valid=1 in a state that consumes it. After WIDTH accepted bits, the first bit is at the MSB.
- States: IDLE, SHIFT, PAR (feature only), HOLD.
- IDLE:
  - sin_valid&sof: shift the bit in, bit_cnt=1, go to SHIFT.
  - sin_valid without sof: ignored; no flags.
- SHIFT:
  - sin_valid&!sof: shift, bit_cnt+1.
  - When the WIDTH-th bit is accepted: go to HOLD, or to PAR if the feature is enabled. dout_valid=1 on the next cycle, one cycle after the last bit.
  - sin_valid&sof: resync. The bit becomes bit 1 of a new frame, bit_cnt=1, frame_err pulses one cycle. Earlier bits are discarded, but dout is not cleared.
  - If WIDTH-1 bits are held and the next bit carries sof, resync wins over completion.
- HOLD:
  - dout and par_err stay stable and dout_valid=1 until dout_valid&dout_ready; no shifting.
  - On handshake: dout_valid=0, bit_cnt=0, go to IDLE.
  - Handshake plus sin_valid&sof in the same cycle: the bit is accepted as bit 1 of the next frame; go directly to SHIFT with bit_cnt=1.
  - sin_valid in HOLD without that handshake: the bit is dropped and overrun<=1.
- overrun: cleared by ovr_clr=1. If a set event and ovr_clr occur in the same cycle, set wins.
- busy=1 in SHIFT and PAR, 0 otherwise.
- bit_cnt holds WIDTH during PAR and HOLD.
- dout_ready is ignored when dout_valid=0.

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined:
  - After the WIDTH-th data bit, the FSM enters PAR and waits for one more accepted bit, the parity bit; it is not shifted into dout.
  - Even parity: par_err=^{dout, parity_bit}. par_err is registered with dout_valid on entering HOLD and cleared on handshake.
  - sin_valid&sof in PAR is a resync, same as in SHIFT.
- Undefined: PAR is never entered and par_err is tied 0. The port list is identical in both builds.

Test Plan:
- Basic frame (WIDTH=8): reset low for 2 cycles, then release. Bits 1,0,1,0,0,1,0,1 on consecutive cycles, sof on the first -> dout=8'hA5, dout_valid=1 one cycle after the 8th bit, bit_cnt=8, busy=0. dout_ready=1 -> IDLE, bit_cnt=0.
- Gapped bits and backpressure: same frame with sin_valid low on alternate cycles -> dout=8'hA5. Hold dout_ready=0 for 5 cycles -> dout and dout_valid stable throughout.
- Overrun: in HOLD drive sin_valid=1 for one cycle without handshake -> overrun=1 sticky and dout unchanged. Assert ovr_clr -> overrun=0 next cycle.
- Resync: send 5 bits, then sof with bit 1 -> frame_err pulses once, bit_cnt=1. Seven more bits 1,1,1,1,1,1,1 -> dout=8'hFF.
- Back-to-back and reset: handshake in the same cycle as sof of the next frame -> no lost bit, second word correct. Drive reset low after 3 bits of a frame -> all outputs 0 next cycle, and the following frame 8'h3C decodes correctly.
- PARITY_CHECK_EN build: send 8'hA5 plus parity bit 0 -> par_err=0. Send 8'hA5 plus parity bit 1 -> par_err=1. dout=8'hA5 in both cases.
